// File: rtl/neuron_weight_update.sv
// neuron_weight_update
// Sequential delta-rule weight updater, the backward companion of the fully
// parallel neuron. It owns the neuron's N weight registers and, on request,
// walks through them one per cycle with a single shared multiplier:
//     w_i <= sat(w_i + (align(err * x_i) >>> lr_shift))
//
// Optional feature: define UPDATE_SAT_CNT_EN to build the saturation event
// counter. Without it, sat_count is tied to zero and no counter logic exists.
//
// Ports:
//   clk           clock
//   rst_n         asynchronous active-low reset (clears weights too)
//   load          parallel-load weights_init (accepted in IDLE only, wins over start)
//   weights_init  initial weights, signed Q WM.WN
//   start         begin an update pass (accepted in IDLE only)
//   in            neuron input vector x, signed Q QM.QN
//   err           error term, signed Q QM.QN, already sign-adjusted
//   lr_shift      learning rate as 2^-lr_shift (0..15)
//   busy          high while a pass is in progress
//   done          one-cycle pulse when a pass completes
//   weights       registered weights driven to the neuron
//   sat_count     saturated-write counter, sticky at 255
module neuron_weight_update #(
    parameter int N  = 2,
    parameter int QM = 3,
    parameter int QN = 5,
    parameter int WM = 6,
    parameter int WN = 10
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               load,
    input  logic signed [N-1:0][WM+WN-1:0]     weights_init,
    input  logic                               start,
    input  logic signed [N-1:0][QM+QN-1:0]     in,
    input  logic signed [QM+QN-1:0]            err,
    input  logic        [3:0]                  lr_shift,
    output logic                               busy,
    output logic                               done,
    output logic signed [N-1:0][WM+WN-1:0]     weights,
    output logic        [7:0]                  sat_count
);

    localparam int D   = QM + QN;
    localparam int W   = WM + WN;
    localparam int IW  = (N > 1) ? $clog2(N) : 1;
    // The product carries 2*QN fraction bits; these move it onto WN.
    localparam int LSH = (WN >= 2 * QN) ? (WN - 2 * QN) : 0;
    localparam int RSH = (WN >= 2 * QN) ? 0 : (2 * QN - WN);
    localparam int AW  = 2 * D + LSH;
    // One guard bit above the wider operand keeps w + delta from wrapping.
    localparam int SW  = ((AW > W) ? AW : W) + 1;

    localparam logic signed [SW-1:0] SUM_MAX = {{(SW - W + 1){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [SW-1:0] SUM_MIN = {{(SW - W + 1){1'b1}}, {(W - 1){1'b0}}};
    localparam logic        [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        UPDATE,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic signed [N-1:0][W-1:0] weights_q;
    logic signed [N-1:0][D-1:0] in_q;
    logic signed [D-1:0]        err_q;
    logic        [3:0]          lr_q;
    logic        [IW-1:0]       index_q;

    logic signed [D-1:0]   x_sel;
    logic signed [W-1:0]   cur_w;
    logic signed [2*D-1:0] prod;
    logic signed [SW-1:0]  aligned;
    logic signed [SW-1:0]  delta;
    logic signed [SW-1:0]  sum;
    logic signed [W-1:0]   new_w;
    logic                  sat_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (!load && start) next_state = UPDATE;
            UPDATE:  if (index_q == LAST_IDX) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign busy    = (state == UPDATE);
    assign done    = (state == DONE);
    assign weights = weights_q;

    // Shared datapath: one multiply per cycle on the currently indexed weight.
    // Sign extension to SW happens before shifting so left alignment cannot
    // overflow and right shifts floor toward -inf.
    always_comb begin
        x_sel   = in_q[index_q];
        cur_w   = weights_q[index_q];
        prod    = err_q * x_sel;
        aligned = (SW'(prod) <<< LSH) >>> RSH;
        delta   = aligned >>> lr_q;
        sum     = SW'(cur_w) + delta;
        sat_hit = 1'b0;
        new_w   = sum[W-1:0];
        if (sum > SUM_MAX) begin
            new_w   = {1'b0, {(W - 1){1'b1}}};
            sat_hit = 1'b1;
        end else if (sum < SUM_MIN) begin
            new_w   = {1'b1, {(W - 1){1'b0}}};
            sat_hit = 1'b1;
        end
    end

    // Operands are captured at start so the caller may change in/err/lr_shift
    // freely during the pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weights_q <= '0;
            in_q      <= '0;
            err_q     <= '0;
            lr_q      <= '0;
            index_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (load) begin
                        weights_q <= weights_init;
                    end else if (start) begin
                        in_q    <= in;
                        err_q   <= err;
                        lr_q    <= lr_shift;
                        index_q <= '0;
                    end
                end
                UPDATE: begin
                    weights_q[index_q] <= new_w;
                    index_q            <= index_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef UPDATE_SAT_CNT_EN
    logic [7:0] sat_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt_q <= '0;
        end else if (state == IDLE && load) begin
            sat_cnt_q <= '0;
        end else if (state == UPDATE && sat_hit && sat_cnt_q != 8'hFF) begin
            sat_cnt_q <= sat_cnt_q + 8'd1;
        end
    end

    assign sat_count = sat_cnt_q;
`else
    assign sat_count = 8'd0;
`endif

endmodule

// File: tb/tb_neuron_weight_update.sv
// tb_neuron_weight_update
// Self-checking bench for neuron_weight_update with default parameters
// (N=2, Q3.5 inputs/error, Q6.10 weights). Table-driven passes plus
// hand-written sequences for mid-pass disturbance, load/start collision,
// mid-pass reset and saturation-counter stickiness.
module tb_neuron_weight_update;

`ifdef UPDATE_SAT_CNT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic                     clk;
    logic                     rst_n;
    logic                     load;
    logic signed [1:0][15:0]  weights_init;
    logic                     start;
    logic signed [1:0][7:0]   in;
    logic signed [7:0]        err;
    logic        [3:0]        lr_shift;
    logic                     busy;
    logic                     done;
    logic signed [1:0][15:0]  weights;
    logic        [7:0]        sat_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] w0;
        logic [15:0] w1;
        logic [7:0]  sat;
    } exp_t;

    typedef struct {
        string       name;
        logic [15:0] init0;
        logic [15:0] init1;
        logic [7:0]  err;
        logic [7:0]  in0;
        logic [7:0]  in1;
        logic [3:0]  lr;
        logic [15:0] exp0;
        logic [15:0] exp1;
        logic [7:0]  sat;
    } vec_t;

    exp_t scoreboard[$];
    vec_t vecs[8];

    neuron_weight_update dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (load),
        .weights_init (weights_init),
        .start        (start),
        .in           (in),
        .err          (err),
        .lr_shift     (lr_shift),
        .busy         (busy),
        .done         (done),
        .weights      (weights),
        .sat_count    (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [15:0] w0, input logic [15:0] w1);
        @(negedge clk);
        load            = 1'b1;
        start           = 1'b0;
        weights_init[0] = w0;
        weights_init[1] = w1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Waits for done with a cycle budget; cycles counts from the start edge.
    task automatic wait_done(output int cycles, output bit ok);
        cycles = 1;
        ok     = 1'b0;
        while (cycles < 20) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic check_output(input string name);
        exp_t e;
        if (scoreboard.size() == 0) begin
            check_val({name, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = scoreboard.pop_front();
        check_val({name, "_w0"}, 32'(weights[0]), 32'(e.w0));
        check_val({name, "_w1"}, 32'(weights[1]), 32'(e.w1));
        check_val({name, "_sat"}, 32'(sat_count), 32'(e.sat));
    endtask

    task automatic apply_stimulus(input string name, input logic [7:0] e, input logic [7:0] x0,
                                  input logic [7:0] x1, input logic [3:0] lr,
                                  input logic [15:0] exp0, input logic [15:0] exp1,
                                  input logic [7:0] sat);
        exp_t eo;
        int   cycles;
        bit   ok;
        @(negedge clk);
        err      = e;
        in[0]    = x0;
        in[1]    = x1;
        lr_shift = lr;
        start    = 1'b1;
        eo.w0 = exp0;
        eo.w1 = exp1;
        eo.sat = SAT_EN ? sat : 8'd0;
        scoreboard.push_back(eo);
        @(negedge clk);
        start = 1'b0;
        check_val({name, "_busy"}, 32'(busy), 32'd1);
        wait_done(cycles, ok);
        check_val({name, "_done_seen"}, 32'(ok), 32'd1);
        check_val({name, "_latency"}, 32'(cycles), 32'd3);
        check_output(name);
        @(negedge clk);
        check_val({name, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int  cycles;
        bit  ok;
        int  done_seen;
        exp_t eo;

        vecs[0] = '{"s1_basic",    16'h0000, 16'h0000, 8'h20, 8'h10, 8'h08, 4'd0,  16'h0200, 16'h0100, 8'd0};
        vecs[1] = '{"s2_lr2",      16'h0000, 16'h0000, 8'h20, 8'h10, 8'h08, 4'd2,  16'h0080, 16'h0040, 8'd0};
        vecs[2] = '{"s3_possat",   16'h7F00, 16'h0000, 8'h7F, 8'h7F, 8'h00, 4'd0,  16'h7FFF, 16'h0000, 8'd1};
        vecs[3] = '{"s4_floor",    16'h0000, 16'h0000, 8'hE0, 8'h10, 8'h00, 4'd10, 16'hFFFF, 16'h0000, 8'd0};
        vecs[4] = '{"s4_lr0",      16'h0000, 16'h0000, 8'hE0, 8'h10, 8'h00, 4'd0,  16'hFE00, 16'h0000, 8'd0};
        vecs[5] = '{"bothsat",     16'h8100, 16'h4000, 8'h80, 8'h7F, 8'h80, 4'd0,  16'h8000, 16'h7FFF, 8'd2};
        vecs[6] = '{"lr15_zero",   16'h1234, 16'h0ABC, 8'h01, 8'h01, 8'h01, 4'd15, 16'h1234, 16'h0ABC, 8'd0};
        vecs[7] = '{"lr15_neg",    16'h0005, 16'h0000, 8'hFF, 8'h01, 8'h01, 4'd15, 16'h0004, 16'hFFFF, 8'd0};

        rst_n        = 1'b0;
        load         = 1'b0;
        start        = 1'b0;
        weights_init = '0;
        in           = '0;
        err          = '0;
        lr_shift     = '0;
        #12;
        check_val("reset_w0", 32'(weights[0]), 32'd0);
        check_val("reset_w1", 32'(weights[1]), 32'd0);
        check_val("reset_busy", 32'(busy), 32'd0);
        check_val("reset_done", 32'(done), 32'd0);
        check_val("reset_sat", 32'(sat_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_load(vecs[i].init0, vecs[i].init1);
            apply_stimulus(vecs[i].name, vecs[i].err, vecs[i].in0, vecs[i].in1, vecs[i].lr,
                           vecs[i].exp0, vecs[i].exp1, vecs[i].sat);
        end

        // Disturb every input during the pass; start is also held into DONE.
        do_load(16'h0000, 16'h0000);
        @(negedge clk);
        err = 8'h20; in[0] = 8'h10; in[1] = 8'h08; lr_shift = 4'd0; start = 1'b1;
        eo.w0 = 16'h0200; eo.w1 = 16'h0100; eo.sat = 8'd0;
        scoreboard.push_back(eo);
        @(negedge clk);
        load = 1'b1; weights_init[0] = 16'h1111; weights_init[1] = 16'h2222;
        err = 8'h7F; in[0] = 8'h55; in[1] = 8'h66; lr_shift = 4'd3;
        wait_done(cycles, ok);
        load = 1'b0;
        check_val("dist_done_seen", 32'(ok), 32'd1);
        check_val("dist_latency", 32'(cycles), 32'd3);
        check_output("dist");
        @(negedge clk);
        start = 1'b0;
        check_val("start_in_done_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check_val("start_in_done_w0", 32'(weights[0]), 32'h0200);

        // load and start together in IDLE: load wins.
        @(negedge clk);
        load = 1'b1; start = 1'b1;
        weights_init[0] = 16'h0AAA; weights_init[1] = 16'h0555;
        err = 8'h20; in[0] = 8'h10; in[1] = 8'h10;
        @(negedge clk);
        load = 1'b0; start = 1'b0;
        check_val("ldst_busy", 32'(busy), 32'd0);
        check_val("ldst_w0", 32'(weights[0]), 32'h0AAA);
        check_val("ldst_w1", 32'(weights[1]), 32'h0555);
        done_seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        check_val("ldst_no_pass", 32'(done_seen), 32'd0);

        // Reset after the first weight write aborts the pass.
        do_load(16'h0000, 16'h0000);
        @(negedge clk);
        err = 8'h20; in[0] = 8'h10; in[1] = 8'h08; lr_shift = 4'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check_val("rst_mid_w0_written", 32'(weights[0]), 32'h0200);
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_w0", 32'(weights[0]), 32'd0);
        check_val("rst_mid_w1", 32'(weights[1]), 32'd0);
        check_val("rst_mid_busy", 32'(busy), 32'd0);
        check_val("rst_mid_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        check_val("rst_mid_no_done", 32'(done_seen), 32'd0);

        // Saturation counter sticks at 255 and clears on load.
        do_load(16'h7FFF, 16'h7FFF);
        for (int p = 0; p < 130; p++) begin
            @(negedge clk);
            err = 8'h7F; in[0] = 8'h7F; in[1] = 8'h7F; lr_shift = 4'd0; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            wait_done(cycles, ok);
            if (!ok) check_val("sticky_done_timeout", 32'(ok), 32'd1);
        end
        check_val("sticky_sat", 32'(sat_count), SAT_EN ? 32'd255 : 32'd0);
        check_val("sticky_w0", 32'(weights[0]), 32'h7FFF);
        do_load(16'h0000, 16'h0000);
        check_val("sat_clear_on_load", 32'(sat_count), 32'd0);

        check_val("sb_drained", 32'(scoreboard.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/neuron_weight_update.md
Name: neuron_weight_update

Overview:
Sequential delta-rule weight updater. It is the backward-direction companion of the fully parallel neuron.
- Holds the neuron's N weight registers and drives them directly into the neuron's weight inputs.
- On request, applies w_i <= sat(w_i + ((err * x_i) aligned) >>> lr_shift) to each weight.
- Uses one shared multiplier, processing one weight per cycle under a small FSM with a start/busy/done handshake.

Parameters:
N, 2, number of weights (neuron fan-in)
QM, 3, integer bits of input/error format (signed Q QM.QN)
QN, 5, fraction bits of input/error format
WM, 6, integer bits of weight format (signed Q WM.WN)
WN, 10, fraction bits of weight format

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
load  input  1  parallel-load weights_init into weight registers (IDLE only)
weights_init  input  [N-1:0][WM+WN-1:0] signed  initial weights
start  input  1  begin update pass (IDLE only)
in  input  [N-1:0][QM+QN-1:0] signed  neuron input vector x used in the forward pass
err  input  QM+QN signed  error term, already sign-adjusted by the caller (delta = +lr*err*x)
lr_shift  input  4  learning rate as 2^-lr_shift
busy  output  1  high while update pass in progress
done  output  1  one-cycle pulse when pass complete
weights  output  [N-1:0][WM+WN-1:0] signed  current weights to neuron
sat_count  output  8  saturation event counter (see Optional Feature)

Behaviour:
- Reset (async, rst_n low): state IDLE, all weights = 0, busy = 0, done = 0, index = 0, sat_count = 0. A reset asserted mid-pass aborts the pass and also clears the weights.
- States: IDLE, UPDATE, DONE.
- IDLE:
  - load=1: weights <= weights_init at the edge; stay IDLE.
  - load=1 and start=1 together: load wins, start is ignored.
  - start=1 with load=0: capture in, err and lr_shift into internal registers; index <= 0; go to UPDATE.
- UPDATE:
  - busy=1.
  - Each edge writes weights[index] using the captured operands, then index++.
  - After the edge that writes index N-1, go to DONE.
  - load and start are ignored; input changes during the pass have no effect because operands were captured.
- DONE: busy=0, done=1 for exactly one cycle; next edge returns to IDLE. Start in the DONE cycle is ignored.
- Latency: start sampled at edge 0 -> weights[k] updated at edge k+1 -> done high during the cycle after edge N. The pass takes N+1 cycles start-to-done. Back-to-back start is accepted at the earliest in the cycle after done.
- Weights not yet processed in a pass hold their value. The weights output is always the registered values (no combinational path from inputs).
- Arithmetic:
  - prod = err * in[index], signed, width 2(QM+QN), 2QN fraction bits.
  - Align to WN fraction bits: if WN >= 2QN, shift left by (WN-2QN); otherwise arithmetic right shift by (2QN-WN) (truncate toward -inf).
  - delta = aligned >>> lr_shift (arithmetic, truncate toward -inf). lr_shift up to 15 is legal.
  - sum = w + delta, computed at a width sufficient to never wrap (at least max(aligned width, WM+WN)+1).
  - Saturate to [-2^(WM+WN-1), 2^(WM+WN-1)-1]. A saturated write counts as a saturation event.

Optional Feature:
Macro UPDATE_SAT_CNT_EN.
- Defined: sat_count increments on every saturated weight write and sticks at 255. It clears on reset or on an accepted load.
- Undefined: no counter logic; sat_count is tied to 0.

Test Plan:
1. Reset, then load weights_init={0,0}; start with err=0x20 (1.0), in={0x10 (0.5), 0x08 (0.25)}, lr_shift=0.
   - Required: weights={0x0200, 0x0100}; busy high 2 cycles; done pulses 1 cycle at cycle 3 after start.
2. Same stimulus as scenario 1 with lr_shift=2.
   - Required: weights={0x0080, 0x0040}.
3. Load w0=0x7F00; err=0x7F, in[0]=0x7F, lr_shift=0.
   - Required: w0=0x7FFF; sat_count=1 when macro defined, 0 otherwise.
4. w0=0, err=0xE0 (-1.0), in[0]=0x10, lr_shift=10.
   - Required: delta=-1, so w0=0xFFFF (floor rounding). With lr_shift=0, w0=0xFE00.
5. Issue start and load during UPDATE, and change in/err mid-pass.
   - Required: both ignored; results equal those of scenario 1.
   - Also required: load+start together in IDLE loads and does not start (busy stays 0).
6. Assert rst_n low during UPDATE after the first weight has been written.
   - Required: weights={0,0}, busy=0, done=0, and no done pulse after release.
